// File: rtl/ahb_pkg.sv
// ============================================================================
// Module : ahb_pkg
// Brief  : Shared AHB encodings, arbiter states and burst-length lookup.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int BEAT_CNT_W = 4;

  // Beats remaining after the NONSEQ; undefined-length INCR counts as 0.
  function automatic logic [BEAT_CNT_W-1:0] burst_len_m1(input logic [2:0] burst);
    logic [BEAT_CNT_W-1:0] len_m1;
    len_m1 = '0;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  len_m1 = 4'd3;
      HBURST_WRAP8,  HBURST_INCR8:  len_m1 = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: len_m1 = 4'd15;
      default:                      len_m1 = 4'd0;
    endcase
    return len_m1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_rr_pick.sv
// ============================================================================
// Module : ahb_rr_pick
// Brief  : Combinational round-robin picker; first requester after ptr_in.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_rr_pick #(
  parameter int NUM_MASTERS      = 4,
  parameter int MASTER_IDX_WIDTH = 2
) (
  input  logic [NUM_MASTERS-1:0]      req_in,
  input  logic [MASTER_IDX_WIDTH-1:0] ptr_in,
  output logic [NUM_MASTERS-1:0]      pick_oh_out,
  output logic [MASTER_IDX_WIDTH-1:0] pick_idx_out,
  output logic                        pick_valid_out
);

  always_comb begin
    int j;
    logic [MASTER_IDX_WIDTH-1:0] w_idx;
    j              = 0;
    w_idx          = '0;
    pick_oh_out    = '0;
    pick_idx_out   = '0;
    pick_valid_out = 1'b0;
    // The last candidate visited is ptr_in itself, so a lone grantee keeps it.
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      j = int'(ptr_in) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      w_idx = MASTER_IDX_WIDTH'(j);
      if (!pick_valid_out && req_in[w_idx]) begin
        pick_valid_out     = 1'b1;
        pick_idx_out       = w_idx;
        pick_oh_out        = '0;
        pick_oh_out[w_idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ahb_arbiter.sv
// ============================================================================
// Module : ahb_arbiter
// Brief  : Round-robin AHB arbiter, re-arbitrating only at burst boundaries.
//          Optional master locking is enabled by defining AHB_LOCK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_arbiter #(
  parameter int NUM_MASTERS      = 4,
  parameter int MASTER_IDX_WIDTH = 2,
  parameter int DEFAULT_MASTER   = 0
) (
  input  logic                        ahb_clk_in,
  input  logic                        ahb_rst_in,
  input  logic [NUM_MASTERS-1:0]      ahb_busreq_in,
  input  logic [1:0]                  ahb_trans_in,
  input  logic [2:0]                  ahb_burst_in,
  input  logic                        ahb_ready_in,
  input  logic                        ahb_resp_in,
`ifdef AHB_LOCK_EN
  input  logic [NUM_MASTERS-1:0]      ahb_lock_in,
  output logic                        ahb_mastlock_out,
`endif
  output logic [NUM_MASTERS-1:0]      ahb_grant_out,
  output logic [MASTER_IDX_WIDTH-1:0] ahb_master_out,
  output logic [MASTER_IDX_WIDTH-1:0] ahb_master_data_out
);

  import ahb_pkg::*;

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num
      $error("ahb_arbiter: NUM_MASTERS must be 2..16");
    end
    if (MASTER_IDX_WIDTH != $clog2(NUM_MASTERS)) begin : g_bad_width
      $error("ahb_arbiter: MASTER_IDX_WIDTH must equal clog2(NUM_MASTERS)");
    end
    if (DEFAULT_MASTER < 0 || DEFAULT_MASTER >= NUM_MASTERS) begin : g_bad_default
      $error("ahb_arbiter: DEFAULT_MASTER out of range");
    end
  endgenerate

  localparam logic [MASTER_IDX_WIDTH-1:0] c_default_idx = MASTER_IDX_WIDTH'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0]      c_default_oh  = NUM_MASTERS'(1) << DEFAULT_MASTER;

  arb_state_e                  r_state, w_state_nxt;
  logic [BEAT_CNT_W-1:0]       r_beat_cnt, w_beat_cnt_nxt, w_len_m1;
  logic [MASTER_IDX_WIDTH-1:0] r_rr_ptr, r_grant_idx;
  logic [NUM_MASTERS-1:0]      w_pick_oh;
  logic [MASTER_IDX_WIDTH-1:0] w_pick_idx;
  logic                        w_pick_valid;
  logic                        w_incr_hold, w_lock_hold, w_regrant;

  ahb_rr_pick #(
    .NUM_MASTERS      (NUM_MASTERS),
    .MASTER_IDX_WIDTH (MASTER_IDX_WIDTH)
  ) u_pick (
    .req_in         (ahb_busreq_in),
    .ptr_in         (r_rr_ptr),
    .pick_oh_out    (w_pick_oh),
    .pick_idx_out   (w_pick_idx),
    .pick_valid_out (w_pick_valid)
  );

  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      r_state    <= ARB;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_len_m1       = burst_len_m1(ahb_burst_in);
    w_state_nxt    = r_state;
    w_beat_cnt_nxt = r_beat_cnt;
    w_lock_hold    = 1'b0;
    // An error abandons the burst even while HREADY is still low.
    if (ahb_resp_in) begin
      w_beat_cnt_nxt = '0;
      w_state_nxt    = ARB;
    end else if (ahb_ready_in) begin
      case (ahb_trans_in)
        HTRANS_NONSEQ: begin
          w_beat_cnt_nxt = w_len_m1;
          w_state_nxt    = (w_len_m1 > 4'd1) ? BURST : ARB;
        end
        HTRANS_SEQ: begin
          if (r_beat_cnt != '0) w_beat_cnt_nxt = r_beat_cnt - 4'd1;
          // Release one beat early so the next owner's NONSEQ is back-to-back.
          if (r_state == BURST && r_beat_cnt <= 4'd2) w_state_nxt = ARB;
        end
        default: ;
      endcase
    end

    // An undefined-length INCR owner keeps the bus while it keeps requesting.
    w_incr_hold = (r_state == ARB) && !ahb_resp_in &&
                  (r_grant_idx == ahb_master_out) && ahb_busreq_in[r_grant_idx] &&
                  ((ahb_trans_in == HTRANS_SEQ) || (ahb_trans_in == HTRANS_BUSY) ||
                   ((ahb_trans_in == HTRANS_NONSEQ) && (ahb_burst_in == HBURST_INCR)));
`ifdef AHB_LOCK_EN
    w_lock_hold = ahb_lock_in[r_grant_idx];
`endif
    w_regrant = ahb_ready_in && (w_state_nxt == ARB) && !w_incr_hold && !w_lock_hold;
  end

  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      ahb_grant_out       <= c_default_oh;
      r_grant_idx         <= c_default_idx;
      r_rr_ptr            <= c_default_idx;
      ahb_master_out      <= c_default_idx;
      ahb_master_data_out <= c_default_idx;
`ifdef AHB_LOCK_EN
      ahb_mastlock_out    <= 1'b0;
`endif
    end else if (ahb_ready_in) begin
      ahb_master_data_out <= ahb_master_out;
      ahb_master_out      <= r_grant_idx;
`ifdef AHB_LOCK_EN
      ahb_mastlock_out    <= ahb_lock_in[r_grant_idx];
`endif
      if (w_regrant) begin
        if (w_pick_valid) begin
          ahb_grant_out <= w_pick_oh;
          r_grant_idx   <= w_pick_idx;
          if (w_pick_idx != r_grant_idx) r_rr_ptr <= w_pick_idx;
        end else begin
          ahb_grant_out <= c_default_oh;
          r_grant_idx   <= c_default_idx;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ahb_arbiter.sv
// ============================================================================
// Module : tb_ahb_arbiter
// Brief  : Directed and random stimulus against a behavioural arbiter model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_arbiter;

  localparam int NM  = 4;
  localparam int DEF = 0;

  logic       ahb_clk_in = 1'b0;
  logic       ahb_rst_in = 1'b1;
  logic [3:0] ahb_busreq_in = '0;
  logic [1:0] ahb_trans_in = '0;
  logic [2:0] ahb_burst_in = '0;
  logic       ahb_ready_in = 1'b1;
  logic       ahb_resp_in = 1'b0;
  logic [3:0] ahb_grant_out;
  logic [1:0] ahb_master_out;
  logic [1:0] ahb_master_data_out;
`ifdef AHB_LOCK_EN
  logic [3:0] ahb_lock_in = '0;
  logic       ahb_mastlock_out;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: indices as plain integers, burst as beats left.
  int m_grant, m_owner, m_data, m_ptr, m_left;
  bit m_frozen, m_mlock;

  int t3_tr [9] = '{2, 3, 3, 1, 3, 3, 3, 3, 3};
  int t4_rd [9] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};

  always #5 ahb_clk_in = ~ahb_clk_in;

  ahb_arbiter #(
    .NUM_MASTERS      (NM),
    .MASTER_IDX_WIDTH (2),
    .DEFAULT_MASTER   (DEF)
  ) dut (
    .ahb_clk_in          (ahb_clk_in),
    .ahb_rst_in          (ahb_rst_in),
    .ahb_busreq_in       (ahb_busreq_in),
    .ahb_trans_in        (ahb_trans_in),
    .ahb_burst_in        (ahb_burst_in),
    .ahb_ready_in        (ahb_ready_in),
    .ahb_resp_in         (ahb_resp_in),
`ifdef AHB_LOCK_EN
    .ahb_lock_in         (ahb_lock_in),
    .ahb_mastlock_out    (ahb_mastlock_out),
`endif
    .ahb_grant_out       (ahb_grant_out),
    .ahb_master_out      (ahb_master_out),
    .ahb_master_data_out (ahb_master_data_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int len_m1(input int b);
    case (b)
      2, 3:    return 3;
      4, 5:    return 7;
      6, 7:    return 15;
      default: return 0;
    endcase
  endfunction

  function automatic bit lock_bit(input int i);
`ifdef AHB_LOCK_EN
    return ahb_lock_in[2'(i)];
`else
    return (i < 0);
`endif
  endfunction

  task automatic model_reset();
    m_grant = DEF; m_owner = DEF; m_data = DEF; m_ptr = DEF;
    m_left = 0; m_frozen = 0; m_mlock = 0;
  endtask

  task automatic model_edge();
    int nl, pick, idx;
    bit nf, hold, incr_like;
    nl = m_left;
    nf = m_frozen;
    if (ahb_resp_in) begin
      nl = 0; nf = 0;
    end else if (ahb_ready_in) begin
      if (ahb_trans_in == 2'd2) begin
        nl = len_m1(int'(ahb_burst_in));
        nf = (nl > 1);
      end else if (ahb_trans_in == 2'd3) begin
        nl = (m_left > 0) ? m_left - 1 : 0;
        if (m_frozen && nl <= 1) nf = 0;
      end
    end
    if (ahb_ready_in) begin
      incr_like = (ahb_trans_in == 2'd1) || (ahb_trans_in == 2'd3) ||
                  (ahb_trans_in == 2'd2 && ahb_burst_in == 3'd1);
      hold = lock_bit(m_grant) ||
             (!m_frozen && !ahb_resp_in && m_grant == m_owner &&
              ahb_busreq_in[2'(m_grant)] && incr_like);
      m_mlock = lock_bit(m_grant);
      m_data  = m_owner;
      m_owner = m_grant;
      if (!nf && !hold) begin
        pick = -1;
        for (int k = 1; k <= NM; k++) begin
          idx = (m_ptr + k) % NM;
          if (pick < 0 && ahb_busreq_in[2'(idx)]) pick = idx;
        end
        if (pick < 0) m_grant = DEF;
        else begin
          if (pick != m_grant) m_ptr = pick;
          m_grant = pick;
        end
      end
    end
    m_left   = nl;
    m_frozen = nf;
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge ahb_clk_in);
    #1;
    chk({tag, "_grant"}, 32'(ahb_grant_out), 32'(4'b0001 << m_grant));
    chk({tag, "_owner"}, 32'(ahb_master_out), 32'(m_owner));
    chk({tag, "_data"}, 32'(ahb_master_data_out), 32'(m_data));
`ifdef AHB_LOCK_EN
    chk({tag, "_mlock"}, 32'(ahb_mastlock_out), 32'(m_mlock));
`endif
  endtask

  // Reset is raised mid-cycle to exercise the asynchronous path.
  task automatic do_reset();
    #3;
    ahb_rst_in = 1'b1;
    #1;
    chk("rst_grant", 32'(ahb_grant_out), 32'h1);
    chk("rst_owner", 32'(ahb_master_out), 32'h0);
    chk("rst_data", 32'(ahb_master_data_out), 32'h0);
    model_reset();
    ahb_busreq_in = '0; ahb_trans_in = '0; ahb_burst_in = '0;
    ahb_ready_in = 1'b1; ahb_resp_in = 1'b0;
`ifdef AHB_LOCK_EN
    ahb_lock_in = '0;
`endif
    @(posedge ahb_clk_in);
    #1;
    ahb_rst_in = 1'b0;
  endtask

  initial begin
    @(posedge ahb_clk_in);
    #1;
    do_reset();

    // Single requester picked up, ownership one beat later.
    ahb_busreq_in = 4'b0100;
    cycle("t1a");
    chk("t1_grant", 32'(ahb_grant_out), 32'b0100);
    chk("t1_owner0", 32'(ahb_master_out), 32'd0);
    cycle("t1b");
    chk("t1_owner2", 32'(ahb_master_out), 32'd2);

    // All request, SINGLE every beat: strict rotation, data lags owner.
    do_reset();
    ahb_busreq_in = 4'hF; ahb_trans_in = 2'd2; ahb_burst_in = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cycle("t2");
      chk("t2_grant", 32'(ahb_grant_out), 32'(4'b0001 << ((k + 1) % 4)));
      chk("t2_owner", 32'(ahb_master_out), 32'(k % 4));
      chk("t2_data", 32'(ahb_master_data_out), 32'((k == 0) ? 0 : (k - 1) % 4));
    end

    // INCR8 from master 1 with master 3 waiting; BUSY at beat 4.
    do_reset();
    ahb_busreq_in = 4'b0010;
    cycle("t3s");
    cycle("t3s");
    chk("t3_setup", 32'(ahb_master_out), 32'd1);
    ahb_burst_in = 3'd5;
    for (int i = 0; i < 9; i++) begin
      ahb_trans_in  = 2'(t3_tr[i]);
      ahb_busreq_in = (i == 8) ? 4'b1000 : 4'b1010;
      cycle("t3");
      chk("t3_grant", 32'(ahb_grant_out), (i < 7) ? 32'b0010 : 32'b1000);
      chk("t3_owner", 32'(ahb_master_out), (i < 8) ? 32'd1 : 32'd3);
    end

    // Five wait states in the middle of an INCR4.
    do_reset();
    ahb_burst_in = 3'd3;
    for (int i = 0; i < 9; i++) begin
      ahb_ready_in  = t4_rd[i][0];
      ahb_trans_in  = (i == 0) ? 2'd2 : 2'd3;
      ahb_busreq_in = (i == 8) ? 4'b0100 : 4'b0101;
      cycle("t4");
      chk("t4_grant", 32'(ahb_grant_out), (i < 7) ? 32'b0001 : 32'b0100);
      chk("t4_owner", 32'(ahb_master_out), (i < 8) ? 32'd0 : 32'd2);
    end

    // ERROR on beat 2 of a WRAP16 from master 2 while master 0 waits.
    do_reset();
    ahb_busreq_in = 4'b0100;
    cycle("t5s");
    cycle("t5s");
    ahb_busreq_in = 4'b0101; ahb_burst_in = 3'd6; ahb_trans_in = 2'd2;
    cycle("t5");
    ahb_trans_in = 2'd3;
    cycle("t5");
    ahb_ready_in = 1'b0; ahb_resp_in = 1'b1;
    cycle("t5");
    chk("t5_err1_grant", 32'(ahb_grant_out), 32'b0100);
    ahb_ready_in = 1'b1; ahb_trans_in = 2'd0;
    cycle("t5");
    chk("t5_err2_grant", 32'(ahb_grant_out), 32'b0001);
    ahb_resp_in = 1'b0; ahb_busreq_in = 4'b0001;
    cycle("t5");
    chk("t5_owner", 32'(ahb_master_out), 32'd0);

`ifdef AHB_LOCK_EN
    // Locked master 2 keeps the bus against masters 0 and 1.
    do_reset();
    ahb_busreq_in = 4'b0100; ahb_lock_in = 4'b0100;
    ahb_trans_in = 2'd2; ahb_burst_in = 3'd0;
    cycle("t6s");
    cycle("t6s");
    chk("t6_mlock1", 32'(ahb_mastlock_out), 32'd1);
    ahb_busreq_in = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      cycle("t6");
      chk("t6_hold", 32'(ahb_grant_out), 32'b0100);
    end
    ahb_lock_in = 4'b0000;
    cycle("t6r");
    chk("t6_rel_grant", 32'(ahb_grant_out), 32'b0001);
    chk("t6_rel_owner", 32'(ahb_master_out), 32'd2);
    chk("t6_mlock0", 32'(ahb_mastlock_out), 32'd0);
    cycle("t6r");
    chk("t6_new_owner", 32'(ahb_master_out), 32'd0);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ahb_busreq_in = 4'($urandom);
      ahb_trans_in  = 2'($urandom);
      ahb_burst_in  = 3'($urandom);
      ahb_ready_in  = ($urandom_range(0, 7) != 0);
      ahb_resp_in   = ($urandom_range(0, 31) == 0);
`ifdef AHB_LOCK_EN
      ahb_lock_in   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
`endif
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
